// File: rtl/sbus_mem.sv
// sbus_mem: SBUS memory-side responder serving quad-word reads and writes from a 36-bit word array.
// Define SBUS_MEM_PAR_EN to check odd address parity (adrPar) and pulse parErr on failures.
module sbus_mem #(
  parameter int MEM_WORDS = 4096,
  parameter int ACC_LAT   = 3
) (
  input  logic        memClk,
  input  logic        CROBAR_N,
  input  logic        start,
  input  logic [21:0] adr,
  input  logic [3:0]  rq,
  input  logic        rdRq,
  input  logic        wrRq,
  input  logic        adrPar,
  input  logic [35:0] dataIn,
  output logic        ack,
  output logic        dataValid,
  output logic [35:0] dataOut,
  output logic        busy,
  output logic        parErr
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [22:0] MEM_LIMIT = 23'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, ACK, WAIT, XFER} state_t;

  state_t        state, state_nx;
  logic [35:0]   mem [MEM_WORDS];
  logic [3:0]    cnt, cnt_nx;
  logic [3:0]    rem, rem_nx;
  logic [1:0]    ptr, ptr_nx;
  logic [1:0]    word;
  logic [AW-1:2] quad;
  logic          is_read;
  logic          serve;
  logic          wr_pend;
  logic [AW-1:0] wr_addr;
  logic          nxm, par_bad, take, accept;

  assign nxm = {1'b0, adr} >= MEM_LIMIT;

`ifdef SBUS_MEM_PAR_EN
  assign par_bad = ~(^{adr, rdRq, wrRq, adrPar});
`else
  logic unused_par;
  assign unused_par = adrPar;
  assign par_bad    = 1'b0;
`endif

  assign busy   = (state != IDLE) | dataValid;
  assign take   = (state == IDLE) & ~busy & start & (rdRq | wrRq) & ~nxm;
  assign accept = take & ~par_bad;

  always_ff @(posedge memClk or negedge CROBAR_N) begin
    if (!CROBAR_N) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      rem   <= rem_nx;
      ptr   <= ptr_nx;
    end
  end

  // rem holds the words still owed; each XFER cycle serves the first one found from ptr, wrapping in the quad
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rem_nx   = rem;
    ptr_nx   = ptr;
    word     = ptr;
    serve    = 1'b0;
    ack      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = ACK;
          rem_nx   = rq;
          ptr_nx   = adr[1:0];
        end
      end
      ACK: begin
        ack    = 1'b1;
        cnt_nx = 4'(ACC_LAT - 1);
        if (rem == 4'b0000)    state_nx = IDLE;
        else if (ACC_LAT == 1) state_nx = XFER;
        else                   state_nx = WAIT;
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = XFER;
      end
      XFER: begin
        for (int k = 3; k >= 0; k--) begin
          if (rem[ptr + 2'(k)]) word = ptr + 2'(k);
        end
        serve  = 1'b1;
        rem_nx = rem & ~(4'b0001 << word);
        ptr_nx = word + 2'd1;
        if (rem_nx == 4'b0000) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs lag the XFER visit by one cycle; a write commits at the end of its dataValid cycle
  always_ff @(posedge memClk or negedge CROBAR_N) begin
    if (!CROBAR_N) begin
      dataValid <= 1'b0;
      dataOut   <= '0;
      parErr    <= 1'b0;
      is_read   <= 1'b0;
      quad      <= '0;
      wr_pend   <= 1'b0;
      wr_addr   <= '0;
    end else begin
      dataValid <= serve;
      parErr    <= take & par_bad;
      wr_pend   <= serve & ~is_read;
      wr_addr   <= {quad, word};
      if (accept) begin
        is_read <= rdRq;
        quad    <= adr[AW-1:2];
      end
      if (serve & is_read) dataOut <= mem[{quad, word}];
    end
  end

  always_ff @(posedge memClk) begin
    if (wr_pend) mem[wr_addr] <= dataIn;
  end

endmodule

// File: doc/sbus_mem.md
Name: sbus_mem

Overview:
- Memory-side responder for the SBUS that the MBOX drives as initiator.
- Accepts quad-word read/write requests (START, address, RQ0-3 mask, RD/WR), acknowledges them, and after a fixed access latency either returns or absorbs the requested words one per cycle.
- Backs an internal word array. Serves as the simulation and FPGA memory module behind the MBOX (stand-in for an MA20/MF20 bank).

Parameters:
- MEM_WORDS, 4096, number of 36-bit words implemented; must be a multiple of 4.
- ACC_LAT, 3, cycles from ACK to first data transfer; legal range 1..15.

Ports:
- memClk  in  1  memory clock; all state updates on the rising edge.
- CROBAR_N  in  1  asynchronous active-low reset.
- start  in  1  request strobe, valid for one cycle.
- adr  in  22  physical word address (bits 14..35); adr[1:0] selects the first word within the quad.
- rq  in  4  word request mask; rq[i] requests quad word i.
- rdRq  in  1  read request, qualified by start.
- wrRq  in  1  write request, qualified by start.
- adrPar  in  1  odd parity over adr, rdRq and wrRq.
- dataIn  in  36  write data, sampled when dataValid=1 during a write.
- ack  out  1  one-cycle acknowledge of an accepted request.
- dataValid  out  1  read: dataOut valid this cycle; write: dataIn taken this cycle.
- dataOut  out  36  read data.
- busy  out  1  request in progress; start is ignored while set.
- parErr  out  1  one-cycle pulse on an address parity failure.

Behaviour:
- Reset (CROBAR_N=0, async): state=IDLE; ack, dataValid, busy and parErr are 0; dataOut=0.
  - Array contents are not reset.
  - Reset mid-transfer aborts immediately; a partially written quad keeps the words already written.
- States: IDLE -> ACK -> WAIT -> XFER -> IDLE.
- IDLE: on start=1 with busy=0, latch adr, rq, op and the quad word index. Then:
  - Neither rdRq nor wrRq set: ignore the request.
  - Both set: treat as read.
  - adr >= MEM_WORDS (nonexistent memory): no ack, stay IDLE; the MBOX NXM timeout handles it.
  - Parity failure (feature enabled): no ack; parErr=1 in the next cycle; stay IDLE.
  - Otherwise: go to ACK.
- ACK: ack=1 and busy=1 for exactly one cycle (the cycle after start).
  - Load the latency counter with ACC_LAT-1.
  - Go to WAIT, or straight to XFER when ACC_LAT=1.
- WAIT: decrement the counter each cycle; at 0, go to XFER.
- XFER: visit quad words in order w=adr[1:0], w+1, w+2, w+3, all modulo 4 (wrap within the aligned quad).
  - Skip unrequested words: they cost 0 cycles, so the next requested word follows in the next cycle.
  - For each requested word: dataValid=1 for one cycle.
  - Read: dataOut = mem[{adr[21:2],w}], registered.
  - Write: mem[{adr[21:2],w}] <= dataIn at that edge.
  - After the last requested word: busy drops, go to IDLE. start in that same cycle is ignored; start the following cycle is accepted.
- rq=0000: ACK then immediately IDLE. No dataValid, busy high for exactly 1 cycle.
- Throughput: one word per cycle. Full quad total = 1 (ack) + ACC_LAT + 4 cycles of busy.
- dataOut holds its last value when dataValid=0.
- ack and dataValid are never high in the same cycle.

Optional Feature:
- SBUS_MEM_PAR_EN
  - Defined: adrPar is checked as odd parity over {adr, rdRq, wrRq}; a failure gives no ack plus a one-cycle parErr pulse.
  - Undefined: adrPar is ignored and parErr is tied 0.

Test Plan:
- Preload mem[0x104..0x107]=1,2,3,4; read adr=0x106, rq=1111, ACC_LAT=3 -> ack at T+1; dataValid at T+5..T+8 with dataOut 3,4,1,2; busy low at T+9.
- Write adr=0x201, rq=0101, dataIn 0o777/0o123 -> dataValid twice in consecutive cycles (words 2 then 0); readback gives mem[0x200]=0o123, mem[0x202]=0o777, mem[0x201]/mem[0x203] unchanged.
- Read with adr=MEM_WORDS (0x1000) -> no ack, busy stays 0 for 10 cycles; next valid request serviced normally.
- SBUS_MEM_PAR_EN defined, adrPar inverted -> no ack, parErr=1 for one cycle at T+1; with the macro undefined, the same stimulus is acked.
- Second start asserted during WAIT -> ignored; exactly one ack and one data sequence. start in the cycle after busy falls -> acked.
- Deassert CROBAR_N during XFER after 2 of 4 write words -> outputs 0 immediately; the two written words persist; the next request works from IDLE.
